// File: rtl/buzzer_sequencer_if.sv
// Command handshake between a note producer and the buzzer sequencer.
// The master drives a 12-bit note command with valid; the slave answers with ready.
interface buzzer_sequencer_if;
  logic [11:0] cmd_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;

  modport master (
    output cmd_i,
    output cmd_valid_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_i,
    input  cmd_valid_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/buzzer_sequencer.sv
// Buzzer note sequencer: a command FIFO feeding a load/play/wait-for-done FSM.
// Defining SEQ_GAP_EN adds a GAP_CYCLES-long silence after every completed note.
module buzzer_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PLAY_HOLD  = 4,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              rst,
  buzzer_sequencer_if.slave cmd,
  input  logic              flush_i,
  input  logic              buzzer_done_i,
  output logic [15:0]       buzzer_cmd_o,
  output logic              busy_o,
  output logic              note_done_o,
  output logic [4:0]        fifo_count_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned HoldW = $clog2(PLAY_HOLD);

`ifdef SEQ_GAP_EN
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {StIdle, StLoad, StPlayHi, StPlayLo, StWaitDone, StGap} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLoad, StPlayHi, StPlayLo, StWaitDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [11:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]        count_q;
  logic              nonempty_q;
  logic [11:0]       held_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic              done_q;
  logic              note_done_q;

  logic full, avail, push, pop, done_rise, hold_last, play, note_done_d;

  assign full            = (count_q == 5'(FIFO_DEPTH));
  assign cmd.cmd_ready_o = ~full & ~flush_i;
  assign push            = cmd.cmd_valid_i & cmd.cmd_ready_o;
  // An entry becomes poppable one cycle after it is written, fixing push-to-play latency.
  assign avail           = nonempty_q & (count_q != 5'd0);
  assign done_rise       = buzzer_done_i & ~done_q;
  assign hold_last       = (hold_cnt_q == HoldW'(PLAY_HOLD - 1));

  // Command FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      nonempty_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      nonempty_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + 5'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 5'd1;
      end
      nonempty_q <= (count_q != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd.cmd_i;
  end

  // Holding register, play-hold counter and done-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q      <= 12'h000;
      hold_cnt_q  <= '0;
      done_q      <= 1'b0;
      note_done_q <= 1'b0;
    end else begin
      done_q      <= buzzer_done_i;
      note_done_q <= note_done_d;
      if (pop) held_q <= mem_q[rd_ptr_q];
      hold_cnt_q  <= (state_q == StPlayHi) ? hold_cnt_q + HoldW'(1) : '0;
    end
  end

`ifdef SEQ_GAP_EN
  logic [GapW-1:0] gap_cnt_q;
  logic            gap_last;

  assign gap_last = (gap_cnt_q == GapW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= (state_q == StGap) ? gap_cnt_q + GapW'(1) : '0;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (avail) state_d = StLoad;
      StLoad:     state_d = (held_q[11:8] == 4'd0) ? StIdle : StPlayHi;
      StPlayHi:   if (hold_last) state_d = StPlayLo;
      StPlayLo:   state_d = StWaitDone;
      StWaitDone: begin
        if (done_rise) begin
`ifdef SEQ_GAP_EN
          state_d = StGap;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef SEQ_GAP_EN
      StGap:      if (gap_last) state_d = StIdle;
`endif
      default:    state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  // FSM outputs
  always_comb begin
    play        = 1'b0;
    busy_o      = 1'b0;
    pop         = 1'b0;
    note_done_d = 1'b0;
    play        = (state_q == StPlayHi);
    busy_o      = (state_q != StIdle);
    pop         = (state_q == StIdle) & avail & ~flush_i;
    note_done_d = (state_q == StWaitDone) & done_rise & ~flush_i;
  end

  assign buzzer_cmd_o = {1'b0, play, 2'b00, held_q};
  assign note_done_o  = note_done_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboarded bench for buzzer_sequencer: directed latency/flush/reset cases plus a
// randomized stream against a queue model of which notes must play and complete.
module tb_buzzer_sequencer;
  localparam int unsigned FifoDepth = 8;
  localparam int unsigned PlayHold  = 4;
  localparam int unsigned GapCycles = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        buzzer_done = 1'b0;
  logic [15:0] buzzer_cmd;
  logic        busy;
  logic        note_done;
  logic [4:0]  fifo_count;

  buzzer_sequencer_if bus ();

  buzzer_sequencer #(
    .FIFO_DEPTH(FifoDepth),
    .PLAY_HOLD (PlayHold),
    .GAP_CYCLES(GapCycles)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd          (bus),
    .flush_i      (flush),
    .buzzer_done_i(buzzer_done),
    .buzzer_cmd_o (buzzer_cmd),
    .busy_o       (busy),
    .note_done_o  (note_done),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_q[$];
  int          note_done_cnt = 0;
  logic        mon_prev_play = 1'b0;
  int          mon_hold = 0;
  logic        auto_done = 1'b0;
  logic        last_play = 1'b0;
  int          done_wait = 0;

`ifdef SEQ_GAP_EN
  localparam logic AfterDoneBusy = 1'b1;
`else
  localparam logic AfterDoneBusy = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every play rise must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      mon_prev_play = 1'b0;
      mon_hold      = 0;
    end else begin
      if (note_done) note_done_cnt++;
      if (buzzer_cmd[14]) begin
        if (!mon_prev_play) begin
          if (exp_q.size() == 0) check("unexpected_play", buzzer_cmd, 16'h0000);
          else check("play_word", buzzer_cmd, exp_q.pop_front());
        end
        mon_hold++;
      end else if (mon_prev_play) begin
        check("play_hold", mon_hold, PlayHold);
        mon_hold = 0;
      end
      mon_prev_play = buzzer_cmd[14];
    end
  end

  // One clock; optionally emulates a buzzer that signals done a few cycles after play falls.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_done) begin
      if (buzzer_done) begin
        buzzer_done = 1'b0;
      end else if (done_wait > 0) begin
        done_wait--;
        if (done_wait == 0) buzzer_done = 1'b1;
      end
      if (last_play && !buzzer_cmd[14]) done_wait = $urandom_range(1, 5);
    end
    last_play = buzzer_cmd[14];
  endtask

  task automatic push(input logic [11:0] c);
    int guard = 0;
    bus.cmd_i       = c;
    bus.cmd_valid_i = 1'b1;
    while (!bus.cmd_ready_o && guard < 500) begin
      step();
      guard++;
    end
    if (!bus.cmd_ready_o) check("push_ready_timeout", bus.cmd_ready_o, 1'b1);
    step();
    bus.cmd_valid_i = 1'b0;
    if (c[11:8] != 4'd0) exp_q.push_back({4'h4, c});
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || fifo_count != 5'd0) && guard < 3000) begin
      step();
      guard++;
    end
    if (busy) check("drain_busy", busy, 1'b0);
    step();
  endtask

  task automatic wait_play_fall();
    int guard = 0;
    while (!(last_play && !buzzer_cmd[14]) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check("play_fall_timeout", buzzer_cmd[14], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] c;
    int          nd0;
    int          exp_notes;
    int          n;

    bus.cmd_i       = 12'h000;
    bus.cmd_valid_i = 1'b0;
    #2;
    check("rst_cmd", buzzer_cmd, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_note_done", note_done, 1'b0);
    check("rst_count", fifo_count, 5'd0);
    check("rst_ready", bus.cmd_ready_o, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single note: latency, word sequence, done handling
    push(12'h349);
    check("lat_e0_count", fifo_count, 5'd1);
    check("lat_e0_cmd", buzzer_cmd, 16'h0000);
    step();
    check("lat_e1_busy", busy, 1'b0);
    step();
    check("lat_e2_load", buzzer_cmd, 16'h0349);
    check("lat_e2_busy", busy, 1'b1);
    check("lat_e2_count", fifo_count, 5'd0);
    step();
    check("lat_e3_play", buzzer_cmd, 16'h4349);
    repeat (PlayHold) step();
    check("play_fell", buzzer_cmd, 16'h0349);
    step();
    nd0 = note_done_cnt;
    buzzer_done = 1'b1;
    step();
    check("done_pulse", note_done, 1'b1);
    check("done_busy", busy, AfterDoneBusy);
    step();
    check("done_pulse_width", note_done, 1'b0);
    buzzer_done = 1'b0;
    step();
    check("done_count_single", note_done_cnt - nd0, 1);
    wait_idle();

    // Zero-duration entry is skipped; the next one starts right away
    nd0 = note_done_cnt;
    push(12'h04A);
    push(12'h123);
    step();
    check("zero_dur_load", buzzer_cmd, 16'h004A);
    step();
    check("zero_dur_idle", busy, 1'b0);
    step();
    step();
    check("zero_dur_next_play", buzzer_cmd, 16'h4123);
    auto_done = 1'b1;
    wait_idle();
    auto_done = 1'b0;
    buzzer_done = 1'b0;
    check("zero_dur_done_count", note_done_cnt - nd0, 1);

    // Fill: 9 pushes, first popped, 8 queued
    for (int i = 0; i < 9; i++) begin
      c       = 12'($urandom);
      c[11:8] = 4'($urandom_range(1, 15));
      push(c);
    end
    check("full_count", fifo_count, 5'd8);
    check("full_ready", bus.cmd_ready_o, 1'b0);
    check("full_wait_busy", busy, 1'b1);
    check("full_wait_play", buzzer_cmd[14], 1'b0);

    // Flush in WAIT_DONE; a later done edge is ignored
    nd0 = note_done_cnt;
    flush = 1'b1;
    #1;
    check("flush_ready", bus.cmd_ready_o, 1'b0);
    step();
    flush = 1'b0;
    exp_q.delete();
    check("flush_count", fifo_count, 5'd0);
    check("flush_busy", busy, 1'b0);
    check("flush_play", buzzer_cmd[14], 1'b0);
    buzzer_done = 1'b1;
    step();
    step();
    buzzer_done = 1'b0;
    step();
    check("flush_done_ignored", note_done_cnt - nd0, 0);
    check("flush_still_idle", busy, 1'b0);

    // Asynchronous reset during PLAY_HI
    push(12'h5A1);
    push(12'h6B2);
    n = 0;
    while (!buzzer_cmd[14] && n < 20) begin
      step();
      n++;
    end
    check("rst_mid_reached_play", buzzer_cmd[14], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_cmd", buzzer_cmd, 16'h0000);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_count", fifo_count, 5'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    last_play = 1'b0;
    step();

`ifdef SEQ_GAP_EN
    // Gap between two queued notes
    push(12'h211);
    push(12'h322);
    wait_play_fall();
    step();
    buzzer_done = 1'b1;
    step();
    check("gap_note_done", note_done, 1'b1);
    buzzer_done = 1'b0;
    n = 0;
    while (!buzzer_cmd[14] && n < 100) begin
      step();
      n++;
    end
    check("gap_done_to_play", n, 12);
    auto_done = 1'b1;
    wait_idle();
    auto_done = 1'b0;
    buzzer_done = 1'b0;
`endif

    // Randomized stream against the queue model
    auto_done = 1'b1;
    nd0       = note_done_cnt;
    exp_notes = 0;
    for (int i = 0; i < 40; i++) begin
      c = 12'($urandom);
      if ($urandom_range(0, 3) == 0) c[11:8] = 4'd0;
      if (c[11:8] != 4'd0) exp_notes++;
      push(c);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    step();
    check("rand_note_done_count", note_done_cnt - nd0, exp_notes);
    check("rand_queue_drained", exp_q.size(), 0);
    auto_done   = 1'b0;
    buzzer_done = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
